// File: rtl/sramc_top.sv
// sramc_top -- 64 KB (16384 x 32-bit) AHB-Lite SRAM slave with a built-in self test.
//
// Ports:
//   hclk, hresetn      clock (rising edge) and asynchronous active-low reset
//   sram_clk           accepted for integration only, not used inside
//   hsel, hready,
//   htrans, hwrite,
//   hsize, haddr       AHB address phase; a transfer is taken when hsel & hready & htrans[1]
//   hburst, dft_en     ignored
//   hwdata             write data, data phase
//   hrdata             read data, combinational during a read data phase, else 0
//   hready_resp, hresp always ready / always OKAY
//   bist_en            level request; while high the BIST owns the memory
//   bist_done,
//   bist_fail          BIST completion and mismatch flags, held until bist_en drops
module sramc_top (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        sram_clk,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hready,
  input  logic [2:0]  hburst,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        dft_en,
  input  logic        bist_en,
  output logic [31:0] hrdata,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic        bist_done,
  output logic        bist_fail
);

  typedef enum logic [1:0] {
    BIST_IDLE  = 2'b00,
    BIST_WRITE = 2'b01,
    BIST_READ  = 2'b10,
    BIST_DONE  = 2'b11
  } bist_state_e;

  // Little-endian lane enables; sub-size address bits are ignored, oversize acts as word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      3'b000:  s = 4'b0001 << lo;
      3'b001:  s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  logic [31:0]  mem [0:16383];

  logic         valid_q, valid_d;
  logic         write_q, write_d;
  logic [15:0]  addr_q,  addr_d;
  logic [2:0]   size_q,  size_d;

  bist_state_e  state_q, state_d;
  logic [13:0]  idx_q,   idx_d;
  logic         done_q,  done_d;
  logic         fail_q,  fail_d;

  logic         ahb_we_s;
  logic [3:0]   strb_s;
  logic         bist_we_s;
  logic [31:0]  bist_rd_s;
  logic         mismatch_s;
  logic         unused_s;

  assign hready_resp = 1'b1;
  assign hresp       = 2'b00;
  assign bist_done   = done_q;
  assign bist_fail   = fail_q;
  assign unused_s    = ^{sram_clk, hburst, dft_en, haddr[31:16], htrans[0]};

  // Address-phase capture: hold previous control when no transfer is taken.
  always_comb begin
    valid_d = hsel & hready & htrans[1];
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (valid_d) begin
      addr_d  = haddr[15:0];
      size_d  = hsize;
      write_d = hwrite;
    end else begin
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;
    end
  end

  // Data-phase write enable and read data; the BIST blocks both directions.
  always_comb begin
    ahb_we_s = valid_q & write_q & ~bist_en;
    strb_s   = byte_strobe(size_q, addr_q[1:0]);
    hrdata   = 32'h0000_0000;
    if (valid_q && !write_q && !bist_en) begin
      hrdata = mem[addr_q[15:2]];
    end else begin
      hrdata = 32'h0000_0000;
    end
  end

  // BIST sequencer: pattern write pass, compare pass, then hold flags until bist_en drops.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = done_q;
    fail_d     = fail_q;
    bist_we_s  = 1'b0;
    bist_rd_s  = mem[idx_q];
    mismatch_s = (bist_rd_s != {18'd0, idx_q});
    if (!bist_en) begin
      state_d = BIST_IDLE;
      idx_d   = 14'd0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        BIST_IDLE: begin
          state_d = BIST_WRITE;
          idx_d   = 14'd0;
        end
        BIST_WRITE: begin
          bist_we_s = 1'b1;
          idx_d     = idx_q + 14'd1;
          if (idx_q == 14'h3FFF) begin
            state_d = BIST_READ;
          end else begin
            state_d = BIST_WRITE;
          end
        end
        BIST_READ: begin
          idx_d  = idx_q + 14'd1;
          fail_d = fail_q | mismatch_s;
          if (idx_q == 14'h3FFF) begin
            state_d = BIST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = BIST_READ;
          end
        end
        BIST_DONE: begin
          state_d = BIST_DONE;
        end
        default: begin
          state_d = BIST_IDLE;
        end
      endcase
    end
  end

  // Control and BIST state registers; a pending write is dropped by reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 16'h0000;
      size_q  <= 3'b000;
      state_q <= BIST_IDLE;
      idx_q   <= 14'd0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  // Memory array, not reset; BIST write and AHB write are mutually exclusive via bist_en.
  always_ff @(posedge hclk) begin
    if (bist_we_s) begin
      mem[idx_q] <= {18'd0, idx_q};
    end else if (ahb_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_s[i]) begin
          mem[addr_q[15:2]][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sramc_top.sv
// Self-checking bench for sramc_top: directed vector table, reset corner case,
// randomized traffic against a byte-level memory model, and a full BIST run.
module tb_sramc_top;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        sram_clk = 1'b0;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b000;
  logic        hready = 1'b1;
  logic [2:0]  hburst = 3'b000;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic        dft_en = 1'b0;
  logic        bist_en = 1'b0;
  logic [31:0] hrdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic        bist_done;
  logic        bist_fail;

  sramc_top dut (
    .hclk(hclk), .hresetn(hresetn), .sram_clk(sram_clk), .hsel(hsel), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hready(hready), .hburst(hburst), .haddr(haddr),
    .hwdata(hwdata), .dft_en(dft_en), .bist_en(bist_en), .hrdata(hrdata),
    .hready_resp(hready_resp), .hresp(hresp), .bist_done(bist_done), .bist_fail(bist_fail)
  );

  always #5 hclk = ~hclk;

  int n_err = 0;
  int n_chk = 0;

  // reference memory: word index -> 32-bit value
  logic [31:0] mdl [int];

  // pending data phase as seen by the bench
  logic        pend_v = 1'b0;
  logic        pend_w = 1'b0;
  logic [31:0] pend_a = 32'h0;
  logic [2:0]  pend_s = 3'b000;
  logic [31:0] pend_d = 32'h0;
  logic [31:0] exp_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void mdl_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int w, nb, base;
    logic [31:0] cur;
    w    = int'(a[15:2]);
    nb   = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    base = (int'(a[1:0]) / nb) * nb;
    cur  = mdl.exists(w) ? mdl[w] : 32'h0;
    for (int b = base; b < base + nb; b++) cur[8*b +: 8] = d[8*b +: 8];
    mdl[w] = cur;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int w;
    w = int'(a[15:2]);
    return mdl.exists(w) ? mdl[w] : 32'h0;
  endfunction

  // one bus cycle: address phase of this transfer, data phase of the previous one
  task automatic step(input logic sel, input logic rdy, input logic wr, input logic [1:0] tr,
                      input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] dat,
                      input bit do_chk);
    hsel = sel; hready = rdy; hwrite = wr; htrans = tr; hsize = sz; haddr = ad;
    hwdata = pend_d;
    hburst = 3'($urandom_range(0, 7));
    dft_en = 1'($urandom_range(0, 1));
    @(posedge hclk);
    if (pend_v && pend_w) mdl_write(pend_a, pend_s, pend_d);
    pend_v = sel && rdy && tr[1];
    pend_w = wr; pend_a = ad; pend_s = sz; pend_d = dat;
    exp_rd = (pend_v && !wr) ? mdl_read(ad) : 32'h0;
    #1;
    if (do_chk) check("rand_hrdata", hrdata, exp_rd);
  endtask

  typedef struct {
    logic        sel;
    logic        rdy;
    logic        wr;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int cnt;
    logic [31:0] ra, rhi, rw, rlo;

    //            sel   rdy   wr    tr     sz      addr          wdata         hrdata
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0010, 32'h0,         32'h1234_5678};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b000, 32'h0000_0021, 32'h0000_AB00, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0020, 32'h0,         32'hFFFF_ABFF};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0030, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b001, 32'h0000_0032, 32'hBEEF_0000, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0030, 32'h0,         32'hBEEF_0000};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0040, 32'h0,         32'hCAFE_F00D};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0001_0040, 32'h5A5A_A5A5, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0040, 32'h0,         32'h5A5A_A5A5};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0050, 32'h1111_1111, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_0050, 32'h2222_2222, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0050, 32'h3333_3333, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 2'b10, 3'b010, 32'h0000_0050, 32'h4444_4444, 32'h0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0050, 32'h0,         32'h1111_1111};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0053, 32'h0,         32'h1111_1111};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b001, 32'h0000_0023, 32'h1234_0000, 32'h0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 2'b11, 3'b010, 32'h0000_0020, 32'h0,         32'h1234_ABFF};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_0020, 32'h0,         32'h0};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 2'b10, 3'b111, 32'h0000_0060, 32'hA1B2_C3D4, 32'h0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 2'b10, 3'b000, 32'h0000_0061, 32'h0,         32'hA1B2_C3D4};

    // reset state
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_hready_resp", {31'd0, hready_resp}, 32'h1);
    check("rst_hresp", {30'd0, hresp}, 32'h0);
    check("rst_bist_done", {31'd0, bist_done}, 32'h0);
    check("rst_bist_fail", {31'd0, bist_fail}, 32'h0);
    hresetn = 1'b1;

    // directed vectors
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].sel, tbl[i].rdy, tbl[i].wr, tbl[i].tr, tbl[i].sz, tbl[i].ad, tbl[i].dat, 1'b0);
      check($sformatf("vec%0d_hrdata", i), hrdata, tbl[i].exp);
      check($sformatf("vec%0d_hresp", i), {29'd0, hready_resp, hresp}, 32'h4);
    end

    // reset during a write data phase discards the write
    step(1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0000_0050, 32'h2222_2222, 1'b0);
    hsel = 1'b0; hwdata = pend_d;
    #2 hresetn = 1'b0;
    @(posedge hclk);
    #1;
    pend_v = 1'b0;
    check("rstdp_hrdata", hrdata, 32'h0);
    check("rstdp_hready_resp", {31'd0, hready_resp}, 32'h1);
    check("rstdp_hresp", {30'd0, hresp}, 32'h0);
    hresetn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0050, 32'h0, 1'b1);
    check("rstdp_keep", hrdata, 32'h1111_1111);

    // randomized traffic over a 64-word window with aliasing upper bits
    for (int k = 0; k < 64; k++) begin
      rhi = $urandom;
      rw  = $urandom;
      ra  = {rhi[15:0], 16'h0400 + 16'(k * 4)};
      step(1'b1, 1'b1, 1'b1, 2'b10, 3'b010, ra, rw, 1'b1);
    end
    for (int k = 0; k < 400; k++) begin
      rhi = $urandom;
      rw  = $urandom;
      rlo = $urandom;
      ra  = {rhi[15:0], 16'h0400 + {8'd0, 2'b00, rlo[7:2], rlo[1:0]}};
      step(($urandom % 8) != 0, ($urandom % 8) != 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ra, rw, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 1'b1);

    // BIST held from reset; AHB write/read during it must be blocked
    hsel = 1'b0; htrans = 2'b00;
    hresetn = 1'b0;
    bist_en = 1'b1;
    @(posedge hclk);
    #1;
    check("bist_rst_done", {31'd0, bist_done}, 32'h0);
    hresetn = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 40000; c++) begin
      hsel = 1'b0; htrans = 2'b00;
      if (c == 20000) begin
        hsel = 1'b1; hwrite = 1'b1; htrans = 2'b10; hsize = 3'b010; haddr = 32'h0000_001C;
      end
      if (c == 20001) hwdata = 32'hDEAD_BEEF;
      if (c == 20005) begin
        hsel = 1'b1; hwrite = 1'b0; htrans = 2'b10; hsize = 3'b010; haddr = 32'h0000_001C;
      end
      @(posedge hclk);
      #1;
      if (c == 20005) check("bist_ahb_rd_zero", hrdata, 32'h0);
      if (bist_done) begin
        cnt = c;
        break;
      end
    end
    check("bist_done", {31'd0, bist_done}, 32'h1);
    check("bist_fail", {31'd0, bist_fail}, 32'h0);
    if (cnt < 32764 || cnt > 32774) check("bist_cycles", cnt, 32769);
    else check("bist_cycles", 32'd1, 32'd1 & {31'd0, bist_done});
    repeat (3) @(posedge hclk);
    #1;
    check("bist_done_hold", {31'd0, bist_done}, 32'h1);
    bist_en = 1'b0;
    @(posedge hclk);
    #1;
    check("bist_done_clr", {31'd0, bist_done}, 32'h0);
    check("bist_fail_clr", {31'd0, bist_fail}, 32'h0);

    // BIST pattern left in memory; the blocked AHB write must not show
    pend_v = 1'b0;
    step(1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_0014, 32'h0, 1'b0);
    check("bist_word5", hrdata, 32'h5);
    step(1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_001C, 32'h0, 1'b0);
    check("bist_word7", hrdata, 32'h7);
    step(1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 32'h0000_FFFC, 32'h0, 1'b0);
    check("bist_word_last", hrdata, 32'h3FFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
